// File: rtl/unstriping_ctrl.sv
// Two-lane unstriping sequencer: qualifies lane alignment, alternates lane_0/lane_1
// into a serial word stream, flags lane mismatches. Optional err_cnt via UNSTRIPING_CTRL_ERRCNT_EN.
module unstriping_ctrl #(
  parameter int LANE_W      = 32,
  parameter int SYNC_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic [LANE_W-1:0] lane_0,
  input  logic [LANE_W-1:0] lane_1,
  output logic [LANE_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_sel,
  output logic              synced,
  output logic              lane_err,
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, ERR} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_CYCLES);

  state_t     state;
  logic [3:0] sync_cnt;

  logic both_hi, both_lo, mismatch;
  assign both_hi  = valid_0 & valid_1;
  assign both_lo  = ~valid_0 & ~valid_1;
  assign mismatch = valid_0 ^ valid_1;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sync_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_sel  <= 1'b0;
      synced    <= 1'b0;
      lane_err  <= 1'b0;
      word_cnt  <= '0;
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          lane_sel <= 1'b0;
          if (both_hi) begin
            if (SYNC_LAST == 4'd1) begin
              state    <= RUN;
              synced   <= 1'b1;
              sync_cnt <= '0;
            end else begin
              state    <= SYNC;
              sync_cnt <= 4'd1;
            end
          end
        end
        SYNC: begin
          if (both_hi) begin
            // Counter holds the number of consecutive aligned cycles seen so far.
            if (4'(sync_cnt + 4'd1) == SYNC_LAST) begin
              state    <= RUN;
              synced   <= 1'b1;
              lane_sel <= 1'b0;
              sync_cnt <= '0;
            end else begin
              sync_cnt <= 4'(sync_cnt + 4'd1);
            end
          end else begin
            state    <= IDLE;
            sync_cnt <= '0;
          end
        end
        RUN: begin
          // Mismatch outranks the clean end-of-burst check.
          if (mismatch || (both_lo && lane_sel)) begin
            state    <= ERR;
            lane_err <= 1'b1;
            synced   <= 1'b0;
            lane_sel <= 1'b0;
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
          end else if (both_lo) begin
            state    <= IDLE;
            synced   <= 1'b0;
            lane_sel <= 1'b0;
          end else begin
            data_out  <= lane_sel ? lane_1 : lane_0;
            valid_out <= 1'b1;
            lane_sel  <= ~lane_sel;
            word_cnt  <= word_cnt + 1'b1;
          end
        end
        ERR: begin
          lane_sel <= 1'b0;
          // Only a fully idle cycle clears the error; never straight back to SYNC.
          if (both_lo) begin
            state    <= IDLE;
            lane_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unstriping_ctrl.sv
// Directed bench for unstriping_ctrl: sync, burst, error, short burst, reset, word_cnt wrap.
module tb_unstriping_ctrl;
  logic        clk_2f = 1'b0;
  logic        reset;
  logic        valid_0, valid_1;
  logic [31:0] lane_0, lane_1;
  logic [31:0] data_out;
  logic        valid_out, lane_sel, synced, lane_err;
  logic [7:0]  word_cnt;
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  unstriping_ctrl #(.LANE_W(32), .SYNC_CYCLES(4), .CNT_W(8)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .valid_0(valid_0), .valid_1(valid_1),
    .lane_0(lane_0), .lane_1(lane_1),
    .data_out(data_out), .valid_out(valid_out), .lane_sel(lane_sel),
    .synced(synced), .lane_err(lane_err),
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .word_cnt(word_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic cyc();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    repeat (2) @(posedge clk_2f);
    #1;
    chk("rst_data", 64'(data_out), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_sel", 64'(lane_sel), 64'h0);
    chk("rst_synced", 64'(synced), 64'h0);
    chk("rst_err", 64'(lane_err), 64'h0);
    chk("rst_cnt", 64'(word_cnt), 64'h0);
    reset = 1'b1;

    // first sync and first pair
    valid_0 = 1; valid_1 = 1; lane_0 = 32'hAAAA0001; lane_1 = 32'hBBBB0001;
    repeat (3) cyc();
    chk("sync3_synced", 64'(synced), 64'h0);
    chk("sync3_valid", 64'(valid_out), 64'h0);
    cyc();
    chk("sync4_synced", 64'(synced), 64'h1);
    chk("sync4_sel", 64'(lane_sel), 64'h0);
    chk("sync4_valid", 64'(valid_out), 64'h0);
    cyc();
    chk("w1_data", 64'(data_out), 64'hAAAA0001);
    chk("w1_valid", 64'(valid_out), 64'h1);
    chk("w1_sel", 64'(lane_sel), 64'h1);
    chk("w1_cnt", 64'(word_cnt), 64'h1);
    cyc();
    chk("w2_data", 64'(data_out), 64'hBBBB0001);
    chk("w2_valid", 64'(valid_out), 64'h1);
    chk("w2_sel", 64'(lane_sel), 64'h0);
    chk("w2_cnt", 64'(word_cnt), 64'h2);

    // pairs 2 and 3, then clean end at lane_sel=0
    for (int p = 2; p <= 3; p++) begin
      lane_0 = 32'hAAAA0000 | 32'(p);
      lane_1 = 32'hBBBB0000 | 32'(p);
      cyc();
      chk("burst_l0", 64'(data_out), 64'(32'hAAAA0000 | 32'(p)));
      cyc();
      chk("burst_l1", 64'(data_out), 64'(32'hBBBB0000 | 32'(p)));
    end
    chk("burst_cnt", 64'(word_cnt), 64'h6);
    valid_0 = 0; valid_1 = 0;
    cyc();
    chk("end_valid", 64'(valid_out), 64'h0);
    chk("end_synced", 64'(synced), 64'h0);
    chk("end_err", 64'(lane_err), 64'h0);
    chk("end_cnt", 64'(word_cnt), 64'h6);
    chk("end_hold", 64'(data_out), 64'hBBBB0003);

    // lane mismatch -> ERR
    valid_0 = 1; valid_1 = 1;
    repeat (4) cyc();
    chk("resync_synced", 64'(synced), 64'h1);
    cyc();
    chk("pre_err_cnt", 64'(word_cnt), 64'h7);
    valid_1 = 0;
    cyc();
    chk("mm_err", 64'(lane_err), 64'h1);
    chk("mm_valid", 64'(valid_out), 64'h0);
    chk("mm_synced", 64'(synced), 64'h0);
    chk("mm_sel", 64'(lane_sel), 64'h0);
    chk("mm_cnt", 64'(word_cnt), 64'h7);
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
    chk("mm_errcnt", 64'(err_cnt), 64'h1);
`endif
    valid_1 = 1;
    cyc();
    chk("err_hold", 64'(lane_err), 64'h1);
    chk("err_nosync", 64'(synced), 64'h0);
    valid_0 = 0; valid_1 = 0;
    cyc();
    chk("err_clear", 64'(lane_err), 64'h0);
    valid_0 = 1; valid_1 = 1;
    repeat (3) cyc();
    chk("rs3_synced", 64'(synced), 64'h0);
    cyc();
    chk("rs4_synced", 64'(synced), 64'h1);
    valid_0 = 0; valid_1 = 0;
    cyc();
    chk("end2_synced", 64'(synced), 64'h0);
    chk("end2_cnt", 64'(word_cnt), 64'h7);

    // short qualification burst never reaches RUN
    valid_0 = 1; valid_1 = 1;
    repeat (2) cyc();
    valid_0 = 0; valid_1 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("short_synced", 64'(synced), 64'h0);
      chk("short_valid", 64'(valid_out), 64'h0);
    end
    chk("short_cnt", 64'(word_cnt), 64'h7);

    // both low on a lane_sel=1 cycle breaks the pair
    valid_0 = 1; valid_1 = 1;
    repeat (5) cyc();
    chk("brk_pre_cnt", 64'(word_cnt), 64'h8);
    valid_0 = 0; valid_1 = 0;
    cyc();
    chk("brk_err", 64'(lane_err), 64'h1);
    chk("brk_valid", 64'(valid_out), 64'h0);
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
    chk("brk_errcnt", 64'(err_cnt), 64'h2);
`endif
    cyc();
    chk("brk_clear", 64'(lane_err), 64'h0);

    // asynchronous reset mid-RUN at lane_sel=1
    valid_0 = 1; valid_1 = 1; lane_0 = 32'hCAFE0000; lane_1 = 32'hF00D0000;
    repeat (5) cyc();
    chk("prerst_sel", 64'(lane_sel), 64'h1);
    chk("prerst_cnt", 64'(word_cnt), 64'h9);
    reset = 1'b0;
    #1;
    chk("arst_data", 64'(data_out), 64'h0);
    chk("arst_valid", 64'(valid_out), 64'h0);
    chk("arst_sel", 64'(lane_sel), 64'h0);
    chk("arst_synced", 64'(synced), 64'h0);
    chk("arst_cnt", 64'(word_cnt), 64'h0);
`ifdef UNSTRIPING_CTRL_ERRCNT_EN
    chk("arst_errcnt", 64'(err_cnt), 64'h0);
`endif
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("post_rst3", 64'(synced), 64'h0);
    chk("post_rst3_valid", 64'(valid_out), 64'h0);
    cyc();
    chk("post_rst4", 64'(synced), 64'h1);
    cyc();
    chk("post_rst_data", 64'(data_out), 64'hCAFE0000);
    chk("post_rst_valid", 64'(valid_out), 64'h1);
    chk("post_rst_cnt", 64'(word_cnt), 64'h1);

    // word_cnt wrap
    repeat (254) cyc();
    chk("wrap_ff", 64'(word_cnt), 64'hFF);
    cyc();
    chk("wrap_0", 64'(word_cnt), 64'h0);
    cyc();
    chk("wrap_1", 64'(word_cnt), 64'h1);
    chk("wrap_valid", 64'(valid_out), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/unstriping_ctrl.md
Name: unstriping_ctrl

Overview:
Sequencing controller for the two-lane unstriping datapath in the clk_2f domain.
- Qualifies lane alignment before accepting data.
- Alternates lane_0/lane_1 selection to rebuild the serial word stream.
- Detects lane valid mismatches and counts delivered words.
- Sits between the per-lane receive logic and the downstream consumer of data_out/valid_out.

Parameters:
- LANE_W, 32, width of each lane word and of data_out.
- SYNC_CYCLES, 4, consecutive clk_2f cycles with valid_0 and valid_1 both high needed to leave SYNC (range 1..15).
- CNT_W, 8, width of word_cnt.

Ports:
- clk_2f  input  1  double-rate clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_0  input  1  lane 0 word valid; held for 2 clk_2f cycles per word.
- valid_1  input  1  lane 1 word valid; held for 2 clk_2f cycles per word.
- lane_0  input  LANE_W  lane 0 word.
- lane_1  input  LANE_W  lane 1 word.
- data_out  output  LANE_W  registered unstriped word.
- valid_out  output  1  data_out qualifier.
- lane_sel  output  1  lane sampled this cycle (0 = lane_0, 1 = lane_1).
- synced  output  1  high while in RUN.
- lane_err  output  1  high while in ERR.
- word_cnt  output  CNT_W  count of cycles with valid_out=1; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; data_out=0, valid_out=0, lane_sel=0, synced=0, lane_err=0, word_cnt=0, sync counter=0.
  - Reset asserted mid-RUN aborts immediately; no partial word is emitted after release.
- States: IDLE, SYNC, RUN, ERR. All outputs are registered.
- IDLE:
  - valid_0 & valid_1 -> SYNC with sync counter=1.
  - If SYNC_CYCLES=1, go straight to RUN.
  - Otherwise stay.
- SYNC:
  - Both valids high -> counter+1; when counter reaches SYNC_CYCLES -> RUN with lane_sel=0.
  - Either valid low -> IDLE, counter=0.
  - No output in SYNC.
- RUN:
  - lane_sel toggles every cycle, starting at 0 on the first RUN cycle.
  - Each cycle: data_out <= (lane_sel ? lane_1 : lane_0); valid_out <= 1. Latency is 1 clk_2f cycle from sample to output.
  - lane_sel=0 cycle with valid_0=valid_1=0 -> IDLE; clean end of burst, valid_out <= 0, data_out holds.
  - Any cycle with valid_0 != valid_1 -> ERR.
  - lane_sel=1 cycle with both valids low -> ERR (pair broken mid-word).
  - In both ERR cases valid_out <= 0 that cycle.
- ERR:
  - lane_err=1, valid_out=0, lane_sel=0.
  - Stays until a cycle with valid_0=valid_1=0, then -> IDLE.
  - A direct ERR->SYNC transition is not allowed.
- word_cnt:
  - Increments on every registered valid_out=1 cycle.
  - Modulo 2^CNT_W; wraps to 0 after all-ones.
  - Not cleared by ERR or IDLE; cleared only by reset.
- Simultaneous events:
  - Mismatch takes priority over the end-of-burst condition.
  - Reset takes priority over everything.

Optional Feature:
- Macro: UNSTRIPING_CTRL_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0].
  - Increments on each entry into ERR; saturates at 255; reset to 0.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then valid_0=valid_1=1 held with lane_0=0xAAAA0001, lane_1=0xBBBB0001 -> synced rises after 4 cycles. Next cycles give data_out=0xAAAA0001 then 0xBBBB0001 with valid_out=1, lane_sel 0,1; word_cnt=2.
- Burst of 3 word pairs ending with both valids low at a lane_sel=0 boundary -> return to IDLE, valid_out=0, word_cnt=6, lane_err=0.
- In RUN, drop valid_1 alone for one cycle -> lane_err=1 next cycle, valid_out=0. Drop both valids -> IDLE. Re-sync needs 4 cycles. With UNSTRIPING_CTRL_ERRCNT_EN: err_cnt=1.
- Both valids high for 2 cycles, then both low (less than SYNC_CYCLES) -> stay out of RUN, synced=0, no valid_out.
- Assert reset for 1 cycle mid-RUN while lane_sel=1 -> all outputs 0 immediately. After release with valids held high, 4-cycle re-sync, first output is lane_0.
- With CNT_W=8, stream 256 words -> word_cnt wraps to 0 and continues incrementing.
